loa_pipe_adder: RTL and testbench

LOA_PIPE_ADDER -- requirements
Module: loa_pipe_adder

---
 rtl/loa_pkg.sv | 20 ++
 rtl/loa_core.sv | 56 +++++
 rtl/loa_pipe_adder.sv | 90 +++++++++
 tb/tb_loa_pipe_adder.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/loa_pkg.sv
// Shared defaults and helpers for the lower-part-OR approximate adder.
//   LOA_WIDTH      : default operand/sum width
//   LOA_MAX_APPROX : default ceiling on approximate lower bits
//   clamp_k        : effective k = min(requested, ceiling)
//   kw_of          : width of the approx_k field for a given ceiling (>=1)
package loa_pkg;

   localparam int LOA_WIDTH      = 16;
   localparam int LOA_MAX_APPROX = 8;

   function automatic int unsigned clamp_k(input int unsigned req, input int unsigned max_k);
      return (req > max_k) ? max_k : req;
   endfunction

   // A ceiling of 0 would give a zero-width field; keep at least one bit.
   function automatic int kw_of(input int max_k);
      return (max_k > 0) ? $clog2(max_k + 1) : 1;
   endfunction

endpackage

// File: rtl/loa_core.sv
// Combinational datapath of the approximate adder, split into the two halves
// that sit on either side of the first pipeline register.
//   Front half (a, b, cin, k -> lower, carry):
//     lower = (a | b) restricted to bits below k, carry = boundary carry.
//   Back half (up_a, up_b, up_lower, up_carry, up_k -> sum, cout):
//     exact ripple add of bits k..WIDTH-1 plus the boundary carry, merged
//     with the registered lower OR result.
// No state.
module loa_core #(
   parameter int WIDTH = 16,
   parameter int KW    = 4
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic [KW-1:0]    k,
   output logic [WIDTH-1:0] lower,
   output logic             carry,
   input  logic [WIDTH-1:0] up_a,
   input  logic [WIDTH-1:0] up_b,
   input  logic [WIDTH-1:0] up_lower,
   input  logic             up_carry,
   input  logic [KW-1:0]    up_k,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   // Ones in bit positions below kk.
   function automatic logic [WIDTH-1:0] mask_of(input logic [KW-1:0] kk);
      logic [WIDTH-1:0] m;
      m = '0;
      for (int i = 0; i < WIDTH; i++) m[i] = (i < int'(kk));
      return m;
   endfunction

   logic [WIDTH-1:0] lo_mask, top_bit, up_mask;
   logic [WIDTH:0]   ext;

   always_comb begin
      lo_mask = mask_of(k);
      // Single-hot at bit k-1; picks a[k-1]&b[k-1] without a variable index.
      top_bit = lo_mask & ~(lo_mask >> 1);
      lower   = (a | b) & lo_mask;
      carry   = (k == '0) ? cin : |(a & b & top_bit);
   end

   always_comb begin
      up_mask = mask_of(up_k);
      // Operand bits below k are zeroed, so carry<<k lands exactly at bit k.
      ext  = {1'b0, up_a & ~up_mask} + {1'b0, up_b & ~up_mask}
           + ({{WIDTH{1'b0}}, up_carry} << up_k);
      sum  = ext[WIDTH-1:0] | up_lower;
      cout = ext[WIDTH];
   end

endmodule

// File: rtl/loa_pipe_adder.sv
// Two-stage pipelined lower-part-OR approximate adder with valid/ready flow.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid/in_ready    : operand handshake (a, b, cin, approx_k)
//   out_valid/out_ready  : result handshake (sum, cout)
// S1 holds the lower OR result, boundary carry, effective k and operands;
// S2 holds the finished sum/cout. Latency is 2 cycles, throughput 1/cycle.
module loa_pipe_adder
   import loa_pkg::*;
#(
   parameter int WIDTH      = LOA_WIDTH,
   parameter int MAX_APPROX = LOA_MAX_APPROX
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [WIDTH-1:0]             a,
   input  logic [WIDTH-1:0]             b,
   input  logic                         cin,
   input  logic [kw_of(MAX_APPROX)-1:0] approx_k,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [WIDTH-1:0]             sum,
   output logic                         cout
);

   localparam int KW = kw_of(MAX_APPROX);

   logic [2:1]       vld_pipe;
   logic [KW-1:0]    k_eff, s1_k;
   logic [WIDTH-1:0] s1_lower, s1_a, s1_b, lower_d, sum_d;
   logic             s1_carry, carry_d, cout_d;
   logic             s2_load, s1_load;

   assign k_eff = KW'(clamp_k(32'(approx_k), MAX_APPROX));

   // S2 takes a new beat when empty or draining; S1 follows it.
   assign s2_load   = !vld_pipe[2] || out_ready;
   assign in_ready  = !vld_pipe[1] || s2_load;
   assign s1_load   = in_valid && in_ready;
   assign out_valid = vld_pipe[2];

   loa_core #(.WIDTH(WIDTH), .KW(KW)) u_core (
      .a        (a),
      .b        (b),
      .cin      (cin),
      .k        (k_eff),
      .lower    (lower_d),
      .carry    (carry_d),
      .up_a     (s1_a),
      .up_b     (s1_b),
      .up_lower (s1_lower),
      .up_carry (s1_carry),
      .up_k     (s1_k),
      .sum      (sum_d),
      .cout     (cout_d)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_pipe <= '0;
         s1_lower <= '0;
         s1_carry <= 1'b0;
         s1_k     <= '0;
         s1_a     <= '0;
         s1_b     <= '0;
         sum      <= '0;
         cout     <= 1'b0;
      end else begin
         if (in_ready) begin
            vld_pipe[1] <= in_valid;
            if (s1_load) begin
               s1_lower <= lower_d;
               s1_carry <= carry_d;
               s1_k     <= k_eff;
               s1_a     <= a;
               s1_b     <= b;
            end
         end
         if (s2_load) begin
            vld_pipe[2] <= vld_pipe[1];
            if (vld_pipe[1]) begin
               sum  <= sum_d;
               cout <= cout_d;
            end
         end
      end
   end

endmodule

// File: tb/tb_loa_pipe_adder.sv
// Scoreboard bench for loa_pipe_adder (WIDTH=16, MAX_APPROX=8).
module tb_loa_pipe_adder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [15:0] a, b, sum;
   logic        cin, cout;
   logic [3:0]  approx_k;

   int          errors = 0;
   int          checks = 0;
   logic [16:0] expq[$];          // {cout, sum}
   logic        saw_in_ready_low = 1'b0;
   int          popped = 0;

   always #5 clk = ~clk;

   loa_pipe_adder #(.WIDTH(16), .MAX_APPROX(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .approx_k(approx_k),
      .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // Reference: OR below k, boundary carry, integer add above k.
   function automatic logic [16:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                         input logic mc, input logic [3:0] mk);
      int unsigned k, lo, c, hi, full;
      k  = (mk > 8) ? 8 : mk;
      lo = 0;
      for (int i = 0; i < 16; i++)
         if (i < k) lo = lo | ((32'(ma) | 32'(mb)) & (32'd1 << i));
      c  = (k == 0) ? 32'(mc) : (((32'(ma) >> (k - 1)) & (32'(mb) >> (k - 1))) & 1);
      hi = (32'(ma) >> k) + (32'(mb) >> k) + c;
      full = (hi << k) | lo;
      return full[16:0];
   endfunction

   // Drive one beat at posedge+1, hold until accepted, push its expectation.
   task automatic send_exp(input logic [15:0] ta, input logic [15:0] tb2, input logic tc,
                           input logic [3:0] tk, input logic [16:0] exp_v);
      logic acc;
      in_valid = 1'b1; a = ta; b = tb2; cin = tc; approx_k = tk;
      acc = 1'b0;
      for (int t = 0; t < 200 && !acc; t++) begin
         @(negedge clk); acc = in_ready;
         @(posedge clk); #1;
      end
      if (!acc) chk("accept_timeout", 32'(acc), 32'd1);
      else expq.push_back(exp_v);
      in_valid = 1'b0;
      a = $urandom; b = $urandom; cin = $urandom; approx_k = $urandom;
   endtask

   task automatic send(input logic [15:0] ta, input logic [15:0] tb2, input logic tc,
                       input logic [3:0] tk);
      send_exp(ta, tb2, tc, tk, model(ta, tb2, tc, tk));
   endtask

   task automatic drain();
      for (int t = 0; t < 200 && expq.size() != 0; t++) @(posedge clk);
      #1;
      chk("drain_empty", expq.size(), 0);
   endtask

   // Monitor: pops on every output transfer, checks hold stability under stall.
   logic        held;
   logic [16:0] held_v;
   initial begin
      logic [16:0] e;
      held = 1'b0;
      held_v = '0;
      forever begin
         @(negedge clk);
         if (in_valid && !in_ready) saw_in_ready_low = 1'b1;
         if (out_valid) begin
            if (held) chk("stall_stable", {cout, sum}, held_v);
            held = !out_ready;
            held_v = {cout, sum};
            if (out_ready) begin
               if (expq.size() == 0) chk("unexpected_out", 32'd1, 32'd0);
               else begin
                  e = expq.pop_front();
                  popped++;
                  chk("result", {cout, sum}, e);
               end
            end
         end else held = 1'b0;
      end
   end

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      a = '0; b = '0; cin = 1'b0; approx_k = '0;
      repeat (2) @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_sum", sum, 0);
      chk("rst_cout", cout, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_in_ready", in_ready, 1);

      // Directed vectors with spec-derived constants; first also checks latency.
      send_exp(16'hFFFF, 16'h0001, 1'b0, 4'd0, {1'b1, 16'h0000});
      @(negedge clk); chk("lat_cycle1_idle", out_valid, 0);
      @(negedge clk); chk("lat_cycle2_valid", out_valid, 1);
      @(posedge clk); #1;
      send_exp(16'h00FF, 16'h0001, 1'b0, 4'd4,  {1'b0, 16'h00FF});
      send_exp(16'h0008, 16'h0008, 1'b1, 4'd4,  {1'b0, 16'h0018});
      send_exp(16'h00FF, 16'h00FF, 1'b0, 4'd12, {1'b0, 16'h01FF});
      drain();

      // Back-to-back beats with a 4-cycle stall.
      saw_in_ready_low = 1'b0;
      popped = 0;
      fork
         for (int i = 0; i < 10; i++) send(16'($urandom), 16'($urandom), 1'($urandom), 4'($urandom_range(0, 15)));
         begin
            repeat (3) begin @(posedge clk); #1; end
            out_ready = 1'b0;
            repeat (4) begin @(posedge clk); #1; end
            out_ready = 1'b1;
         end
      join
      drain();
      chk("bp_in_ready_dropped", saw_in_ready_low, 1);
      chk("bp_count", popped, 10);

      // Randomised traffic with random gaps and random backpressure.
      begin
         bit done = 0;
         fork
            begin
               for (int i = 0; i < 200; i++) begin
                  if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
                  send(16'($urandom), 16'($urandom), 1'($urandom), 4'($urandom_range(0, 15)));
               end
               done = 1;
            end
            while (!done) begin
               out_ready = 1'($urandom_range(0, 2) != 0);
               @(posedge clk); #1;
            end
         join
      end
      out_ready = 1'b1;
      drain();

      // Reset with two beats in flight.
      out_ready = 1'b0;
      send(16'h1234, 16'h4321, 1'b0, 4'd2);
      send(16'hAAAA, 16'h5555, 1'b1, 4'd0);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_sum", sum, 0);
      expq.delete();
      @(negedge clk); rst_n = 1'b1;
      out_ready = 1'b1;
      begin
         int stale = 0;
         for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid) stale++;
         end
         chk("no_stale_after_rst", stale, 0);
      end
      @(posedge clk); #1;
      send(16'h0F0F, 16'h00F1, 1'b0, 4'd3);
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, limit reached");
      $fatal(1);
   end

endmodule
